// File: rtl/run_ctrl.sv
// run_ctrl: load/run/step sequencer between host pulses and a core.
// Defining RUN_CTRL_AUTOSTEP_EN adds the timed auto-step mode (state 5).
module run_ctrl #(
  parameter int LOAD_TIMEOUT_W = 24,
  parameter int STEP_DIV_W     = 22
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       run_pulse,
  input  logic       step_pulse,
  input  logic       load_pulse,
  input  logic       autostep_sel,
  input  logic       core_loaded,
  input  logic       core_executing,
  output logic       start_req,
  output logic       step_req,
  output logic       load_req,
  output logic [4:0] state_id,
  output logic       load_err,
  output logic [7:0] step_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOADING  = 3'd1,
    ST_READY    = 3'd2,
    ST_RUNNING  = 3'd3,
    ST_STEPPING = 3'd4,
    ST_AUTOSTEP = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Limit is 2^W-1 cycles; the counter is compared before its final increment.
  localparam logic [LOAD_TIMEOUT_W-1:0] TMO_LAST = {{(LOAD_TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [LOAD_TIMEOUT_W-1:0] tmo_cnt_r;
  logic                      exec_d_r;
  logic                      done_evt_s;
  logic                      start_nxt_s;
  logic                      step_nxt_s;
  logic                      load_nxt_s;
  logic                      tmo_evt_s;
  logic                      ready_entry_s;

`ifdef RUN_CTRL_AUTOSTEP_EN
  logic [STEP_DIV_W-1:0] div_cnt_r;
  logic                  auto_entry_s;
  logic                  div_tick_s;

  assign div_tick_s = &div_cnt_r;
`else
  logic unused_s;

  assign unused_s = autostep_sel & (STEP_DIV_W > 0);
`endif

  assign done_evt_s = exec_d_r & ~core_executing;
  assign state_id   = {2'b00, state_r};

  // Next-state and request decode; load beats run beats step beats completion.
  always_comb begin
    state_nxt_s   = state_r;
    start_nxt_s   = 1'b0;
    step_nxt_s    = 1'b0;
    load_nxt_s    = 1'b0;
    tmo_evt_s     = 1'b0;
    ready_entry_s = 1'b0;
`ifdef RUN_CTRL_AUTOSTEP_EN
    auto_entry_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOADING: begin
        if (core_loaded) begin
          state_nxt_s   = ST_READY;
          ready_entry_s = 1'b1;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_IDLE;
          tmo_evt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_LOADING;
        end
      end
      ST_READY: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else if (run_pulse) begin
`ifdef RUN_CTRL_AUTOSTEP_EN
          if (autostep_sel) begin
            state_nxt_s  = ST_AUTOSTEP;
            step_nxt_s   = 1'b1;
            auto_entry_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUNNING;
            start_nxt_s = 1'b1;
          end
`else
          state_nxt_s = ST_RUNNING;
          start_nxt_s = 1'b1;
`endif
        end else if (step_pulse) begin
          state_nxt_s = ST_STEPPING;
          step_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      ST_RUNNING: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else if (done_evt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUNNING;
        end
      end
      ST_STEPPING: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else if (run_pulse) begin
          state_nxt_s = ST_RUNNING;
          start_nxt_s = 1'b1;
        end else if (step_pulse) begin
          state_nxt_s = ST_STEPPING;
          step_nxt_s  = 1'b1;
        end else if (done_evt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_STEPPING;
        end
      end
`ifdef RUN_CTRL_AUTOSTEP_EN
      ST_AUTOSTEP: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else if (run_pulse) begin
          state_nxt_s = ST_RUNNING;
          start_nxt_s = 1'b1;
        end else if (step_pulse) begin
          state_nxt_s = ST_STEPPING;
        end else if (done_evt_s) begin
          state_nxt_s = ST_DONE;
        end else if (div_tick_s) begin
          state_nxt_s = ST_AUTOSTEP;
          step_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_AUTOSTEP;
        end
      end
`endif
      ST_DONE: begin
        if (load_pulse) begin
          state_nxt_s = ST_LOADING;
          load_nxt_s  = 1'b1;
        end else if (run_pulse) begin
          state_nxt_s = ST_RUNNING;
          start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, registered request pulses and completion edge history.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      start_req <= 1'b0;
      step_req  <= 1'b0;
      load_req  <= 1'b0;
      exec_d_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      start_req <= start_nxt_s;
      step_req  <= step_nxt_s;
      load_req  <= load_nxt_s;
      exec_d_r  <= core_executing;
    end
  end

  // Load timeout counter and sticky error; every LOADING entry issues load_req.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_r <= {LOAD_TIMEOUT_W{1'b0}};
      load_err  <= 1'b0;
    end else begin
      if (load_nxt_s) begin
        tmo_cnt_r <= {LOAD_TIMEOUT_W{1'b0}};
      end else if (state_r == ST_LOADING) begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end
      if (tmo_evt_s) begin
        load_err <= 1'b1;
      end else if (load_nxt_s) begin
        load_err <= 1'b0;
      end
    end
  end

  // Step counter, cleared on READY entry, wrapping at 8 bits.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      step_count <= 8'd0;
    end else if (ready_entry_s) begin
      step_count <= 8'd0;
    end else if (step_nxt_s) begin
      step_count <= step_count + 8'd1;
    end
  end

`ifdef RUN_CTRL_AUTOSTEP_EN
  // Auto-step divider, restarted on each AUTOSTEP entry.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r <= {STEP_DIV_W{1'b0}};
    end else if (auto_entry_s) begin
      div_cnt_r <= {STEP_DIV_W{1'b0}};
    end else if (state_r == ST_AUTOSTEP) begin
      div_cnt_r <= div_cnt_r + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a cycle-level behavioural model checked every cycle.
module tb_run_ctrl;

  localparam int LW         = 5;
  localparam int SW         = 4;
  localparam int TMO_LIMIT  = (1 << LW) - 1;
  localparam int DIV_PERIOD = 1 << SW;
`ifdef RUN_CTRL_AUTOSTEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int S_IDLE = 0, S_LOADING = 1, S_READY = 2, S_RUNNING = 3;
  localparam int S_STEPPING = 4, S_AUTOSTEP = 5, S_DONE = 6;

  logic       CLK;
  logic       resetn;
  logic       run_pulse, step_pulse, load_pulse, autostep_sel;
  logic       core_loaded, core_executing;
  logic       start_req, step_req, load_req, load_err;
  logic [4:0] state_id;
  logic [7:0] step_count;

  int n_err = 0;
  int n_chk = 0;

  run_ctrl #(.LOAD_TIMEOUT_W(LW), .STEP_DIV_W(SW)) dut (
    .CLK(CLK), .resetn(resetn),
    .run_pulse(run_pulse), .step_pulse(step_pulse), .load_pulse(load_pulse),
    .autostep_sel(autostep_sel), .core_loaded(core_loaded), .core_executing(core_executing),
    .start_req(start_req), .step_req(step_req), .load_req(load_req),
    .state_id(state_id), .load_err(load_err), .step_count(step_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    int st;
    bit start;
    bit step;
    bit load;
    bit err;
    int cnt;
    int tmo;
    int div;
    bit prev_exec;
  } mdl_t;

  mdl_t m;

  // One clock of behaviour: pick the winning pulse, see whether this state honours it,
  // otherwise fall back to loading progress, completion or the auto-step timer.
  function automatic mdl_t nxt(input mdl_t c, input bit ld, input bit rn, input bit sp,
                               input bit asel, input bit loaded, input bit exec);
    mdl_t n;
    bit   fin;
    bit   busy;
    int   w;
    n = c;
    n.start = 1'b0;
    n.step = 1'b0;
    n.load = 1'b0;
    n.prev_exec = exec;
    fin  = c.prev_exec && !exec;
    busy = (c.st == S_RUNNING) || (c.st == S_STEPPING) || (c.st == S_AUTOSTEP);
    w = ld ? 1 : (rn ? 2 : (sp ? 3 : 0));
    if (w == 1 && c.st != S_LOADING) begin
      n.st = S_LOADING; n.load = 1'b1; n.err = 1'b0; n.tmo = 0;
    end else if (w == 2 && (c.st == S_READY || c.st == S_STEPPING ||
                            c.st == S_AUTOSTEP || c.st == S_DONE)) begin
      if (c.st == S_READY && asel && AUTO) begin
        n.st = S_AUTOSTEP; n.step = 1'b1; n.div = 0;
      end else begin
        n.st = S_RUNNING; n.start = 1'b1;
      end
    end else if (w == 3 && (c.st == S_READY || c.st == S_STEPPING || c.st == S_AUTOSTEP)) begin
      n.st = S_STEPPING;
      n.step = (c.st != S_AUTOSTEP);
    end else if (c.st == S_LOADING) begin
      n.tmo = c.tmo + 1;
      if (loaded) begin
        n.st = S_READY; n.cnt = 0;
      end else if (n.tmo == TMO_LIMIT) begin
        n.st = S_IDLE; n.err = 1'b1;
      end
    end else if (fin && busy) begin
      n.st = S_DONE;
    end else if (c.st == S_AUTOSTEP) begin
      n.div = c.div + 1;
      if (n.div % DIV_PERIOD == 0) n.step = 1'b1;
    end
    if (n.step) n.cnt = (c.cnt + 1) % 256;
    return n;
  endfunction

  always @(posedge CLK or negedge resetn) begin
    if (!resetn) m <= '0;
    else m <= nxt(m, load_pulse, run_pulse, step_pulse, autostep_sel, core_loaded, core_executing);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("mdl_state_id", int'(state_id), m.st);
      chk("mdl_start_req", int'(start_req), int'(m.start));
      chk("mdl_step_req", int'(step_req), int'(m.step));
      chk("mdl_load_req", int'(load_req), int'(m.load));
      chk("mdl_load_err", int'(load_err), int'(m.err));
      chk("mdl_step_count", int'(step_count), m.cnt);
    end
  end

  task automatic pulse(input bit ld, input bit rn, input bit sp);
    @(negedge CLK);
    load_pulse = ld; run_pulse = rn; step_pulse = sp;
    @(negedge CLK);
    load_pulse = 1'b0; run_pulse = 1'b0; step_pulse = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    run_pulse = 1'b0; step_pulse = 1'b0; load_pulse = 1'b0; autostep_sel = 1'b0;
    core_loaded = 1'b0; core_executing = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    cmp_en = 1'b1;
    chk("rst_state", int'(state_id), 0);
    chk("rst_reqs", int'({start_req, step_req, load_req}), 0);
    chk("rst_err", int'(load_err), 0);
    chk("rst_count", int'(step_count), 0);
    @(negedge CLK);
    resetn = 1'b1;

    // Load completes three cycles after entering LOADING
    pulse(1'b1, 1'b0, 1'b0);
    chk("load_state", int'(state_id), 1);
    chk("load_req_hi", int'(load_req), 1);
    wait_n(2);
    core_loaded = 1'b1;
    wait_n(1);
    chk("ready_state", int'(state_id), 2);
    chk("ready_err", int'(load_err), 0);
    chk("load_req_lo", int'(load_req), 0);
    core_loaded = 1'b0;

    // Three steps then completion
    core_executing = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    chk("step_state", int'(state_id), 4);
    chk("step_req_hi", int'(step_req), 1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("step_count3", int'(step_count), 3);
    core_executing = 1'b0;
    wait_n(1);
    chk("step_done", int'(state_id), 6);

    // Re-run from DONE; step ignored while RUNNING
    core_executing = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    chk("rerun_state", int'(state_id), 3);
    chk("rerun_start", int'(start_req), 1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("run_ign_step", int'(state_id), 3);
    chk("run_no_stepreq", int'(step_req), 0);
    core_executing = 1'b0;
    wait_n(1);
    chk("run_done", int'(state_id), 6);
    core_loaded = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(1);
    chk("reload_ready", int'(state_id), 2);

    // Coincident pulses: load wins
    pulse(1'b1, 1'b1, 1'b1);
    chk("prio_state", int'(state_id), 1);
    chk("prio_reqs", int'({start_req, step_req, load_req}), 1);
    wait_n(1);

    // Auto-step selection
    core_executing = 1'b1;
    autostep_sel = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    autostep_sel = 1'b0;
`ifdef RUN_CTRL_AUTOSTEP_EN
    chk("auto_state", int'(state_id), 5);
    chk("auto_entry_req", int'(step_req), 1);
    wait_n(64);
    chk("auto_count5", int'(step_count), 5);
    chk("auto_hold", int'(state_id), 5);
    pulse(1'b0, 1'b0, 1'b1);
    chk("auto_to_step", int'(state_id), 4);
    chk("auto_step_noreq", int'(step_req), 0);
`else
    chk("noauto_state", int'(state_id), 3);
    chk("noauto_start", int'(start_req), 1);
`endif
    pulse(1'b1, 1'b0, 1'b0);
    wait_n(1);
    chk("ready_again", int'(state_id), 2);
    chk("ready_count0", int'(step_count), 0);

    // step_count wraps 255 -> 0
    for (int i = 0; i < 256; i++) pulse(1'b0, 1'b0, 1'b1);
    chk("wrap_count", int'(step_count), 0);

    // Completion coinciding with a step pulse is discarded
    @(negedge CLK);
    step_pulse = 1'b1; core_executing = 1'b0;
    @(negedge CLK);
    step_pulse = 1'b0;
    chk("coinc_state", int'(state_id), 4);
    chk("coinc_req", int'(step_req), 1);
    chk("coinc_count", int'(step_count), 1);
    wait_n(2);
    chk("coinc_stay", int'(state_id), 4);
    pulse(1'b0, 1'b1, 1'b0);
    core_executing = 1'b1;
    wait_n(1);
    core_executing = 1'b0;
    wait_n(1);
    chk("run2_done", int'(state_id), 6);

    // Load timeout
    core_loaded = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("tmo_enter", int'(state_id), 1);
    wait_n(30);
    chk("tmo_30", int'(state_id), 1);
    wait_n(1);
    chk("tmo_31_state", int'(state_id), 0);
    chk("tmo_31_err", int'(load_err), 1);
    wait_n(3);
    chk("tmo_sticky", int'(load_err), 1);

    // Reset while RUNNING
    core_loaded = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    chk("reload_clr_err", int'(load_err), 0);
    wait_n(1);
    core_executing = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    chk("pre_rst_start", int'(start_req), 1);
    #1 resetn = 1'b0;
    #1;
    chk("async_state", int'(state_id), 0);
    chk("async_reqs", int'({start_req, step_req, load_req}), 0);
    chk("async_count", int'(step_count), 0);
    @(negedge CLK);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_start", int'(start_req), 0);
      chk("post_rst_state", int'(state_id), 0);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
